arm_pipelined_memory_responder: RTL

Memory-side responder for the pipelined ARM core: it answers the core's instruction-fetch port (PC to instruction) and data port (address, write data, read data) from one single-ported word RAM. Stores are posted into a small write buffer and drained when the RAM port is free. Loads and fetches are forwarded from that buffer. When the port is taken by a load or a forced drain, the block raises a fetch-stall request to the hazard unit.

---
 rtl/arm_pipelined_memory_responder_if.sv | 33 +++
 rtl/arm_pipelined_memory_responder.sv | 108 ++++++++++
 2 files changed

// File: rtl/arm_pipelined_memory_responder_if.sv
// Core-to-memory bus for the pipelined ARM responder.
// Carries the instruction-fetch port (i_PC, i_Fetch_Hold -> o_Instr), the data
// port (i_Data_Addr, i_Write_Data, i_Mem_Write, i_Mem_Read -> o_Read_Data),
// the fetch-stall request to the hazard unit (o_Fetch_Stall) and the
// write-buffer occupancy (o_WBuf_Count).
// master: the core side. slave: the memory responder.
interface arm_pipelined_memory_responder_if #(
  parameter int BusWidth  = 32,
  parameter int WBufDepth = 2
);
  localparam int CountWidth = $clog2(WBufDepth + 1);

  logic [BusWidth-1:0]   i_PC;
  logic                  i_Fetch_Hold;
  logic [BusWidth-1:0]   o_Instr;
  logic [BusWidth-1:0]   i_Data_Addr;
  logic [BusWidth-1:0]   i_Write_Data;
  logic                  i_Mem_Write;
  logic                  i_Mem_Read;
  logic [BusWidth-1:0]   o_Read_Data;
  logic                  o_Fetch_Stall;
  logic [CountWidth-1:0] o_WBuf_Count;

  modport master (
    output i_PC, i_Fetch_Hold, i_Data_Addr, i_Write_Data, i_Mem_Write, i_Mem_Read,
    input  o_Instr, o_Read_Data, o_Fetch_Stall, o_WBuf_Count
  );

  modport slave (
    input  i_PC, i_Fetch_Hold, i_Data_Addr, i_Write_Data, i_Mem_Write, i_Mem_Read,
    output o_Instr, o_Read_Data, o_Fetch_Stall, o_WBuf_Count
  );
endinterface

// File: rtl/arm_pipelined_memory_responder.sv
// Memory responder for the pipelined ARM core.
// One single-ported word RAM serves both instruction fetch and data accesses.
// Stores are posted into a small FIFO write buffer and drained when the RAM
// port is otherwise free; reads forward from that buffer.
// Ports:
//   i_CLK     clock, rising edge
//   i_NRESET  asynchronous active-low reset (empties the write buffer only)
//   bus       slave side of arm_pipelined_memory_responder_if
module arm_pipelined_memory_responder #(
  parameter int BusWidth  = 32,
  parameter int AddrWidth = 10,
  parameter int WBufDepth = 2
) (
  input logic i_CLK,
  input logic i_NRESET,
  arm_pipelined_memory_responder_if.slave bus
);
  localparam int CW = $clog2(WBufDepth + 1);

  typedef enum logic [2:0] {
    GNT_IDLE,
    GNT_LOAD,
    GNT_FORCED_DRAIN,
    GNT_FETCH,
    GNT_IDLE_DRAIN
  } grant_t;

  logic [BusWidth-1:0]  mem [0:(1<<AddrWidth)-1];

  // Entry 0 is the oldest (head); entries 0..count-1 are valid.
  logic [AddrWidth-1:0] buf_idx  [WBufDepth];
  logic [BusWidth-1:0]  buf_data [WBufDepth];
  logic [CW-1:0]        count;

  grant_t               grant;
  logic [AddrWidth-1:0] pc_idx, data_idx, rd_idx;
  logic [BusWidth-1:0]  rd_data;
  logic                 is_load, full, do_drain, enq;
  logic [CW-1:0]        wr_pos;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_PC[1:0], bus.i_PC[BusWidth-1:AddrWidth+2],
                              bus.i_Data_Addr[1:0], bus.i_Data_Addr[BusWidth-1:AddrWidth+2]};

  assign pc_idx   = bus.i_PC[AddrWidth+1:2];
  assign data_idx = bus.i_Data_Addr[AddrWidth+1:2];
  // Read and write both high counts as a store, so no load happens.
  assign is_load  = bus.i_Mem_Read & ~bus.i_Mem_Write;
  assign full     = (count == CW'(WBufDepth));
  assign enq      = bus.i_Mem_Write;

  always_comb begin
    grant = GNT_IDLE;
    if (is_load)                      grant = GNT_LOAD;
    else if (bus.i_Mem_Write && full) grant = GNT_FORCED_DRAIN;
    else if (!bus.i_Fetch_Hold)       grant = GNT_FETCH;
    else if (count != '0)             grant = GNT_IDLE_DRAIN;
  end

  assign do_drain = (grant == GNT_FORCED_DRAIN) || (grant == GNT_IDLE_DRAIN);
  // When the head leaves this edge, everything shifts down one slot.
  assign wr_pos   = do_drain ? count - 1'b1 : count;

  // Single forwarded read; the youngest matching buffer entry overrides RAM.
  always_comb begin
    rd_idx  = (grant == GNT_LOAD) ? data_idx : pc_idx;
    rd_data = mem[rd_idx];
    for (int i = 0; i < WBufDepth; i++) begin
      if ((CW'(i) < count) && (buf_idx[i] == rd_idx)) rd_data = buf_data[i];
    end
  end

  assign bus.o_Instr       = (grant == GNT_FETCH) ? rd_data : '0;
  assign bus.o_Read_Data   = (grant == GNT_LOAD)  ? rd_data : '0;
  assign bus.o_Fetch_Stall = ((grant == GNT_LOAD) || (grant == GNT_FORCED_DRAIN)) &&
                             !bus.i_Fetch_Hold;
  assign bus.o_WBuf_Count  = count;

  // RAM is never cleared; count is zero under reset so no drain can commit.
  always_ff @(posedge i_CLK) begin
    if (do_drain) mem[buf_idx[0]] <= buf_data[0];
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      count <= '0;
      for (int i = 0; i < WBufDepth; i++) begin
        buf_idx[i]  <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      if (do_drain) begin
        for (int i = 0; i < WBufDepth - 1; i++) begin
          buf_idx[i]  <= buf_idx[i+1];
          buf_data[i] <= buf_data[i+1];
        end
      end
      for (int i = 0; i < WBufDepth; i++) begin
        if (enq && (CW'(i) == wr_pos)) begin
          buf_idx[i]  <= data_idx;
          buf_data[i] <= bus.i_Write_Data;
        end
      end
      if (enq && !do_drain)      count <= count + 1'b1;
      else if (!enq && do_drain) count <= count - 1'b1;
    end
  end
endmodule
